// File: rtl/decode_queue.sv
// decode_queue
//   Multi-lane decode stage and in-order issue queue between IFD and IX.
//   Up to FETCH_W fetched instructions per cycle are decoded at enqueue
//   time and stored, compacted in program order, in a DEPTH-entry FIFO.
//   One decoded entry per cycle is offered to IX under valid/ready.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   flush                 WB branch redirect, discards every entry
//   in_valid[FETCH_W]     per-lane valid
//   in_instr, in_pc       lane i at bits [32i+31:32i]
//   in_ready              at least FETCH_W free slots (from registered count)
//   out_valid/out_ready   head handshake towards IX
//   out_instr, out_pc     raw instruction / PC of the head
//   out_a1/a2/rd          decoded register indices
//   out_reg_write         head writes rd (never when rd == 0)
//   out_exe_pipe          one-hot pipe: [0] ALU [1] MUL [2] DIV [3] LSU
//   out_illegal           unrecognised encoding
//   count                 occupied entries
module decode_queue #(
    parameter int          FETCH_W              = 2,
    parameter int          DEPTH                = 8,
    parameter logic [11:0] CSR_REG_DCACHE_FLUSH = 12'h7C0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [FETCH_W-1:0]       in_valid,
    input  logic [FETCH_W*32-1:0]    in_instr,
    input  logic [FETCH_W*32-1:0]    in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [4:0]               out_a1,
    output logic [4:0]               out_a2,
    output logic [4:0]               out_rd,
    output logic                     out_reg_write,
    output logic [3:0]               out_exe_pipe,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] PIPE_ALU = 4'b0001;
    localparam logic [3:0] PIPE_MUL = 4'b0010;
    localparam logic [3:0] PIPE_DIV = 4'b0100;
    localparam logic [3:0] PIPE_LSU = 4'b1000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic        reg_write;
        logic [3:0]  exe_pipe;
        logic        illegal;
    } entry_t;

    function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
        entry_t d;
        d.instr     = instr;
        d.pc        = pc;
        d.a1        = instr[19:15];
        d.a2        = instr[24:20];
        d.rd        = instr[11:7];
        d.reg_write = 1'b0;
        d.exe_pipe  = 4'b0000;
        d.illegal   = 1'b0;
        case (instr[6:0])
            7'b0110011: begin
                d.reg_write = 1'b1;
                // funct7[0] selects the M extension, funct3[2] splits MUL/DIV
                if (!instr[25])      d.exe_pipe = PIPE_ALU;
                else if (!instr[14]) d.exe_pipe = PIPE_MUL;
                else                 d.exe_pipe = PIPE_DIV;
            end
            7'b0000011: begin
                d.exe_pipe  = PIPE_LSU;
                d.reg_write = 1'b1;
                d.a2        = 5'd0;
            end
            7'b0100011: begin
                d.exe_pipe = PIPE_LSU;
                d.rd       = 5'd0;
            end
            7'b1100011: begin
                d.exe_pipe = PIPE_ALU;
                d.rd       = 5'd0;
            end
            7'b0010011, 7'b1100111: begin
                d.exe_pipe  = PIPE_ALU;
                d.reg_write = 1'b1;
                d.a2        = 5'd0;
            end
            7'b1101111, 7'b0110111, 7'b0010111: begin
                d.exe_pipe  = PIPE_ALU;
                d.reg_write = 1'b1;
                d.a1        = 5'd0;
                d.a2        = 5'd0;
            end
            7'b0001111: begin
                d.a1 = 5'd0;
                d.a2 = 5'd0;
                d.rd = 5'd0;
                if (instr[14:12] == 3'b001) d.exe_pipe = PIPE_ALU;
            end
            7'b1110011: begin
                d.a1 = 5'd0;
                d.a2 = 5'd0;
                d.rd = 5'd0;
                if (instr[14:12] == 3'b001 && instr[31:20] == CSR_REG_DCACHE_FLUSH)
                    d.exe_pipe = PIPE_LSU;
            end
            default: begin
                d.illegal = 1'b1;
                d.a1      = 5'd0;
                d.a2      = 5'd0;
                d.rd      = 5'd0;
            end
        endcase
        if (d.rd == 5'd0) d.reg_write = 1'b0;
        return d;
    endfunction

    entry_t             r_mem [DEPTH];
    entry_t             r_head;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    entry_t             w_lane_dec [FETCH_W];
    logic [PTR_W-1:0]   w_slot [FETCH_W];
    logic [CNT_W-1:0]   w_enq_num;
    logic               w_enq;
    logic               w_deq;
    logic [PTR_W-1:0]   w_wr_ptr_next;
    logic [PTR_W-1:0]   w_rd_ptr_next;
    logic [CNT_W-1:0]   w_count_next;
    entry_t             w_head_next;

    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_lane
            assign w_lane_dec[gi] = decode(in_instr[32*gi +: 32], in_pc[32*gi +: 32]);
        end
    endgenerate

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it,
    // which compacts the bundle while keeping program order.
    always_comb begin
        w_enq_num = '0;
        for (int l = 0; l < FETCH_W; l++) begin
            w_slot[l] = r_wr_ptr + w_enq_num[PTR_W-1:0];
            if (in_valid[l]) w_enq_num = w_enq_num + CNT_W'(1);
        end
    end

    assign in_ready  = (CNT_W'(DEPTH) - r_count) >= CNT_W'(FETCH_W);
    assign out_valid = (r_count != '0);
    assign w_enq     = in_ready && (|in_valid) && !flush;
    assign w_deq     = out_valid && out_ready && !flush;

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (flush) begin
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
            w_count_next  = '0;
        end else begin
            if (w_enq) begin
                w_wr_ptr_next = r_wr_ptr + w_enq_num[PTR_W-1:0];
                w_count_next  = w_count_next + w_enq_num;
            end
            if (w_deq) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
                w_count_next  = w_count_next - CNT_W'(1);
            end
        end
    end

    // The head register is loaded with whatever will sit at the read pointer
    // after this edge; a lane being written into that slot right now has to
    // be forwarded because the array write is not visible until the edge.
    always_comb begin
        w_head_next = r_mem[w_rd_ptr_next];
        for (int l = 0; l < FETCH_W; l++) begin
            if (w_enq && in_valid[l] && (w_slot[l] == w_rd_ptr_next))
                w_head_next = w_lane_dec[l];
        end
        if (w_count_next == '0) w_head_next = '0;
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < FETCH_W; l++) begin
            if (w_enq && in_valid[l]) r_mem[w_slot[l]] <= w_lane_dec[l];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_head   <= w_head_next;
        end
    end

    always_ff @(posedge clk) begin
        assert (r_count <= CNT_W'(DEPTH));
    end

    assign count         = r_count;
    assign out_instr     = r_head.instr;
    assign out_pc        = r_head.pc;
    assign out_a1        = r_head.a1;
    assign out_a2        = r_head.a2;
    assign out_rd        = r_head.rd;
    assign out_reg_write = r_head.reg_write;
    assign out_exe_pipe  = r_head.exe_pipe;
    assign out_illegal   = r_head.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Testbench for decode_queue (FETCH_W=2, DEPTH=8).
// Stimulus tasks push hand-decoded expected entries into a scoreboard when
// the bundle is accepted; a monitor pops and compares on every issue.
module tb_decode_queue;

    localparam int FETCH_W = 2;
    localparam int DEPTH   = 8;

    logic                  clk;
    logic                  rst;
    logic                  flush;
    logic [FETCH_W-1:0]    in_valid;
    logic [FETCH_W*32-1:0] in_instr;
    logic [FETCH_W*32-1:0] in_pc;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [31:0]           out_pc;
    logic [4:0]            out_a1;
    logic [4:0]            out_a2;
    logic [4:0]            out_rd;
    logic                  out_reg_write;
    logic [3:0]            out_exe_pipe;
    logic                  out_illegal;
    logic [3:0]            count;

    decode_queue #(.FETCH_W(FETCH_W), .DEPTH(DEPTH), .CSR_REG_DCACHE_FLUSH(12'h7C0)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_a1(out_a1), .out_a2(out_a2), .out_rd(out_rd),
        .out_reg_write(out_reg_write), .out_exe_pipe(out_exe_pipe),
        .out_illegal(out_illegal), .count(count)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  rd;
        logic        rw;
        logic [3:0]  pipe;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                                input logic rw, input logic [3:0] pipe, input logic ill);
        exp_t e;
        e.instr = instr; e.pc = pc; e.a1 = a1; e.a2 = a2; e.rd = rd;
        e.rw = rw; e.pipe = pipe; e.ill = ill;
        return e;
    endfunction

    // hand-decoded reference vectors
    function automatic exp_t e_add (input logic [31:0] pc); return mk(32'h003100B3, pc, 5'd2, 5'd3, 5'd1, 1'b1, 4'b0001, 1'b0); endfunction
    function automatic exp_t e_mul (input logic [31:0] pc); return mk(32'h027302B3, pc, 5'd6, 5'd7, 5'd5, 1'b1, 4'b0010, 1'b0); endfunction
    function automatic exp_t e_div (input logic [31:0] pc); return mk(32'h023140B3, pc, 5'd2, 5'd3, 5'd1, 1'b1, 4'b0100, 1'b0); endfunction
    function automatic exp_t e_sw  (input logic [31:0] pc); return mk(32'h0020A223, pc, 5'd1, 5'd2, 5'd0, 1'b0, 4'b1000, 1'b0); endfunction
    function automatic exp_t e_nop (input logic [31:0] pc); return mk(32'h00000013, pc, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0001, 1'b0); endfunction
    function automatic exp_t e_ill (input logic [31:0] pc); return mk(32'hFFFFFFFF, pc, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b1); endfunction
    function automatic exp_t e_fnci(input logic [31:0] pc); return mk(32'h0000100F, pc, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0001, 1'b0); endfunction
    function automatic exp_t e_lw  (input logic [31:0] pc); return mk(32'h00012083, pc, 5'd2, 5'd0, 5'd1, 1'b1, 4'b1000, 1'b0); endfunction
    function automatic exp_t e_beq (input logic [31:0] pc); return mk(32'h00208463, pc, 5'd1, 5'd2, 5'd0, 1'b0, 4'b0001, 1'b0); endfunction
    function automatic exp_t e_lui (input logic [31:0] pc); return mk(32'h123450B7, pc, 5'd0, 5'd0, 5'd1, 1'b1, 4'b0001, 1'b0); endfunction
    function automatic exp_t e_dcf (input logic [31:0] pc); return mk(32'h7C001073, pc, 5'd0, 5'd0, 5'd0, 1'b0, 4'b1000, 1'b0); endfunction
    function automatic exp_t e_csr (input logic [31:0] pc); return mk(32'h30001073, pc, 5'd0, 5'd0, 5'd0, 1'b0, 4'b0000, 1'b0); endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge. Holds the bundle until accepted.
    task automatic send(input logic [1:0] v, input exp_t e0, input exp_t e1);
        int waited;
        waited = 0;
        in_valid = v;
        in_instr = {e1.instr, e0.instr};
        in_pc    = {e1.pc, e0.pc};
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) break;
            tick();
        end
        if (in_ready) begin
            if (v[0]) sb.push_back(e0);
            if (v[1]) sb.push_back(e1);
            $display("enqueue lanes=%b pc0=%h pc1=%h", v, e0.pc, e1.pc);
        end else begin
            chk("send_timeout", 32'(in_ready), 32'd1);
        end
        tick();
        in_valid = '0;
    endtask

    task automatic wait_empty(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (count == 4'd0) break;
            tick();
        end
        chk("drain_count", 32'(count), 32'd0);
    endtask

    // monitor: one comparison per issued entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            exp_t got;
            exp_t req;
            got = mk(out_instr, out_pc, out_a1, out_a2, out_rd, out_reg_write, out_exe_pipe, out_illegal);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got instr=%h pc=%h, expected no entry", out_instr, out_pc);
            end else begin
                req = sb.pop_front();
                if (got !== req) begin
                    errors++;
                    $display("FAIL issue: got instr=%h pc=%h a1=%0d a2=%0d rd=%0d rw=%0d pipe=%b ill=%0d, expected instr=%h pc=%h a1=%0d a2=%0d rd=%0d rw=%0d pipe=%b ill=%0d",
                             got.instr, got.pc, got.a1, got.a2, got.rd, got.rw, got.pipe, got.ill,
                             req.instr, req.pc, req.a1, req.a2, req.rd, req.rw, req.pipe, req.ill);
                end else begin
                    $display("issue pc=%h instr=%h pipe=%b", got.pc, got.instr, got.pipe);
                end
            end
        end
    end

    // per-cycle occupancy, ready/valid and idle-output checks
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("count_vs_scoreboard", 32'(count), 32'(sb.size()));
            chk("in_ready_rule", 32'(in_ready), 32'(sb.size() <= DEPTH - FETCH_W));
            chk("out_valid_rule", 32'(out_valid), 32'(sb.size() != 0));
            if (!out_valid)
                chk("idle_outputs_zero",
                    out_instr | out_pc | 32'(out_a1) | 32'(out_a2) | 32'(out_rd) |
                    32'(out_reg_write) | 32'(out_exe_pipe) | 32'(out_illegal), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // pipe classes and special encodings
        out_ready = 1'b1;
        send(2'b11, e_add(32'h100), e_mul(32'h104));
        send(2'b11, e_div(32'h108), e_sw(32'h10C));
        send(2'b11, e_nop(32'h110), e_ill(32'h114));
        send(2'b11, e_fnci(32'h118), e_lw(32'h11C));
        send(2'b11, e_beq(32'h120), e_lui(32'h124));
        send(2'b11, e_dcf(32'h128), e_csr(32'h12C));
        wait_empty(30);

        // compaction: only lane 1 valid
        out_ready = 1'b0;
        send(2'b10, e_ill(32'h500), e_add(32'h604));
        chk("compact_count", 32'(count), 32'd1);
        chk("compact_head_pc", out_pc, 32'h604);
        out_ready = 1'b1;
        wait_empty(10);

        // asynchronous reset with 5 entries queued
        out_ready = 1'b0;
        send(2'b11, e_add(32'h700), e_mul(32'h704));
        send(2'b11, e_div(32'h708), e_sw(32'h70C));
        send(2'b01, e_lw(32'h710), e_lw(32'h714));
        chk("pre_reset_count", 32'(count), 32'd5);
        #1;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        chk("async_reset_out_pc", out_pc, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // backpressure to full, then drain with continuous enqueue across wrap
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send(2'b11, e_add(32'h2000 + 32'(8*k)), e_mul(32'h2004 + 32'(8*k)));
        chk("full_count", 32'(count), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) tick();
        chk("stable_head_pc", out_pc, 32'h2000);
        chk("stable_head_instr", out_instr, 32'h003100B3);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k[0]) send(2'b11, e_lw(32'h3000 + 32'(8*k)), e_sw(32'h3004 + 32'(8*k)));
            else      send(2'b11, e_mul(32'h3000 + 32'(8*k)), e_add(32'h3004 + 32'(8*k)));
        end
        wait_empty(40);

        // flush together with enqueue and dequeue at count 4
        out_ready = 1'b0;
        send(2'b11, e_add(32'h4000), e_mul(32'h4004));
        send(2'b11, e_div(32'h4008), e_sw(32'h400C));
        chk("pre_flush_count", 32'(count), 32'd4);
        flush = 1'b1;
        out_ready = 1'b1;
        in_valid = 2'b11;
        in_instr = {32'h027302B3, 32'h003100B3};
        in_pc = {32'h4804, 32'h4800};
        @(negedge clk);
        sb.delete();
        tick();
        flush = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        send(2'b11, e_lw(32'h5000), e_beq(32'h5004));
        wait_empty(10);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
